// File: rtl/cordic_gain_comp_out.sv
// cordic_gain_comp_out: final CORDIC stage. Scales x/y by the gain constant K
// (unsigned Q1.31), passes z through, and buffers results in a small FWFT FIFO.
// Optional macro CORDIC_GAIN_ROUND_EN: round-half-up before the >>>31 instead
// of truncation toward -inf.
module cordic_gain_comp_out #(
  parameter logic [31:0]  K_COEF = 32'h4DBA76D4,
  parameter int unsigned  DEPTH  = 4,
  parameter int unsigned  AW     = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [31:0]   x,
  input  logic [31:0]   y,
  input  logic [31:0]   z,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [31:0]   x_out,
  output logic [31:0]   y_out,
  output logic [31:0]   z_out,
  output logic [AW:0]   count,
  output logic          overflow
);

  localparam int unsigned DW = 32;
  localparam int unsigned EW = 3 * DW;
  localparam int unsigned PW = 64;

`ifdef CORDIC_GAIN_ROUND_EN
  localparam logic signed [PW-1:0] RND = PW'(64'sd1 <<< 30);
`else
  localparam logic signed [PW-1:0] RND = '0;
`endif

  // Signed sample times positive Q1.31 gain, optionally rounded, back to Q31.
  function automatic logic [DW-1:0] f_scale(input logic [DW-1:0] v);
    logic signed [PW-1:0] p;
    p = PW'(signed'(v)) * $signed({32'd0, K_COEF});
    p = p + RND;
    return DW'(p >>> 31);
  endfunction

  logic [DW-1:0] w_px;
  logic [DW-1:0] w_py;

  assign w_px = f_scale(x);
  assign w_py = f_scale(y);

  logic          r_s1_valid;
  logic [DW-1:0] r_px;
  logic [DW-1:0] r_py;
  logic [DW-1:0] r_pz;

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;

  logic          w_full;
  logic          w_pop;
  logic          w_push;

  assign w_full = (r_count == (AW+1)'(DEPTH));
  assign w_pop  = out_valid && out_ready;
  assign w_push = r_s1_valid && (!w_full || w_pop);

  // Stage 1: register the scaled products alongside z and valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_px       <= '0;
      r_py       <= '0;
      r_pz       <= '0;
    end else begin
      r_s1_valid <= in_valid;
      r_px       <= w_px;
      r_py       <= w_py;
      r_pz       <= z;
    end
  end

  // FIFO storage: cleared on reset so the head reads zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= {r_px, r_py, r_pz};
    end
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + (AW+1)'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - (AW+1)'(1);
      end
      if (r_s1_valid && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // First-word-fall-through head presentation.
  assign out_valid = (r_count != '0);
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign {x_out, y_out, z_out} = r_mem[r_rd_ptr];

endmodule

// File: tb/tb_cordic_gain_comp_out.sv
module tb_cordic_gain_comp_out;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [31:0]   x;
  logic [31:0]   y;
  logic [31:0]   z;
  logic          out_ready;
  logic          out_valid;
  logic [31:0]   x_out;
  logic [31:0]   y_out;
  logic [31:0]   z_out;
  logic [AW:0]   count;
  logic          overflow;

  cordic_gain_comp_out #(.K_COEF(32'h4DBA76D4), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .y(y), .z(z),
    .out_ready(out_ready), .out_valid(out_valid), .x_out(x_out), .y_out(y_out),
    .z_out(z_out), .count(count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] ex;
    logic [31:0] ey;
    logic [31:0] ez;
  } ent_t;

  ent_t q[$];
  bit   m_s1v;
  ent_t m_s1;
  bit   m_ovf;
  bit   chk_en;
  int   n_tests;
  int   n_fail;

  // Reference: floor((v * K [+ 2^30]) / 2^31), low 32 bits.
  function automatic logic [31:0] m_scale(input logic [31:0] v);
    longint kk;
    longint p;
    kk = 64'h4DBA76D4;
    p  = longint'($signed(v)) * kk;
`ifdef CORDIC_GAIN_ROUND_EN
    p  = p + 64'd1073741824;
`endif
    return 32'(p >>> 31);
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model after the edge, settle to next negedge+1.
  task automatic step(input logic iv, input logic [31:0] xi, input logic [31:0] yi,
                      input logic [31:0] zi, input logic rdy, input logic rs);
    bit pop;
    in_valid  = iv;
    x         = xi;
    y         = yi;
    z         = zi;
    out_ready = rdy;
    rst       = rs;
    @(posedge clk);
    if (rs) begin
      q.delete();
      m_s1v = 1'b0;
      m_ovf = 1'b0;
    end else begin
      pop = (q.size() != 0) && rdy;
      if (pop) void'(q.pop_front());
      if (m_s1v) begin
        if (q.size() < DEPTH) q.push_back(m_s1);
        else m_ovf = 1'b1;
      end
      m_s1v = iv;
      m_s1  = '{ex: m_scale(xi), ey: m_scale(yi), ez: zi};
    end
    @(negedge clk);
    #1;
  endtask

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("out_valid", 32'(out_valid), 32'(q.size() != 0));
      cmp("count", 32'(count), 32'(q.size()));
      cmp("overflow", 32'(overflow), 32'(m_ovf));
      if (q.size() != 0) begin
        cmp("x_out", x_out, q[0].ex);
        cmp("y_out", y_out, q[0].ey);
        cmp("z_out", z_out, q[0].ez);
      end
    end
  end

  logic [31:0] fill_x [4];
  logic [31:0] rnd_one;

  initial begin
    n_tests = 0; n_fail = 0; chk_en = 1'b0;
    m_s1v = 1'b0; m_ovf = 1'b0; m_s1 = '0;
    in_valid = 1'b0; x = '0; y = '0; z = '0; out_ready = 1'b0; rst = 1'b1;
`ifdef CORDIC_GAIN_ROUND_EN
    fill_x[0] = 32'd1; fill_x[1] = 32'd1; fill_x[2] = 32'd2; fill_x[3] = 32'd2;
    rnd_one = 32'd1;
`else
    fill_x[0] = 32'd0; fill_x[1] = 32'd1; fill_x[2] = 32'd1; fill_x[3] = 32'd2;
    rnd_one = 32'd0;
`endif
    #1;
    step(1'b0, '0, '0, '0, 1'b0, 1'b1);
    chk_en = 1'b1;
    step(1'b1, 32'h1234, 32'h5678, 32'h9, 1'b1, 1'b1);

    // Reset state.
    cmp("rst_out_valid", 32'(out_valid), 32'd0);
    cmp("rst_count", 32'(count), 32'd0);
    cmp("rst_overflow", 32'(overflow), 32'd0);
    cmp("rst_x_out", x_out, 32'd0);
    cmp("rst_y_out", y_out, 32'd0);
    cmp("rst_z_out", z_out, 32'd0);

    // Single sample, two-edge latency.
    step(1'b1, 32'h40000000, 32'hC0000000, 32'h00000123, 1'b0, 1'b0);
    cmp("lat1_out_valid", 32'(out_valid), 32'd0);
    step(1'b0, '0, '0, '0, 1'b0, 1'b0);
    cmp("single_valid", 32'(out_valid), 32'd1);
    cmp("single_x", x_out, 32'h26DD3B6A);
    cmp("single_y", y_out, 32'hD922C496);
    cmp("single_z", z_out, 32'h00000123);
    cmp("single_count", 32'(count), 32'd1);
    step(1'b0, '0, '0, '0, 1'b1, 1'b0);
    cmp("single_popped", 32'(out_valid), 32'd0);

    // Rounding of the smallest magnitudes.
    step(1'b1, '0, 32'h00000001, '0, 1'b0, 1'b0);
    step(1'b1, '0, 32'hFFFFFFFF, '0, 1'b0, 1'b0);
    step(1'b0, '0, '0, '0, 1'b0, 1'b0);
    cmp("round_pos1", y_out, rnd_one);
    step(1'b0, '0, '0, '0, 1'b1, 1'b0);
    cmp("round_neg1", y_out, 32'hFFFFFFFF);
    step(1'b0, '0, '0, '0, 1'b1, 1'b0);

    // Fill and overflow.
    for (int i = 1; i <= 5; i++) step(1'b1, 32'(i), '0, 32'(i), 1'b0, 1'b0);
    step(1'b0, '0, '0, '0, 1'b0, 1'b0);
    step(1'b0, '0, '0, '0, 1'b0, 1'b0);
    cmp("fill_count", 32'(count), 32'd4);
    cmp("fill_overflow", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) begin
      cmp("fill_order", x_out, fill_x[i]);
      step(1'b0, '0, '0, '0, 1'b1, 1'b0);
    end
    cmp("fill_drained", 32'(out_valid), 32'd0);
    step(1'b0, '0, '0, '0, 1'b0, 1'b1);

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 5; i++) step(1'b1, $urandom, $urandom, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, $urandom, $urandom, $urandom, 1'b1, 1'b0);
    cmp("full_pp_count", 32'(count), 32'd4);
    cmp("full_pp_overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 6; i++) step(1'b0, '0, '0, '0, 1'b1, 1'b0);

    // Reset mid-stream with one sample in flight and in_valid during reset.
    for (int i = 0; i < 4; i++) step(1'b1, $urandom, $urandom, $urandom, 1'b0, 1'b0);
    step(1'b1, $urandom, $urandom, $urandom, 1'b0, 1'b1);
    cmp("midrst_count", 32'(count), 32'd0);
    cmp("midrst_valid", 32'(out_valid), 32'd0);
    cmp("midrst_overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, '0, 1'b1, 1'b0);
    cmp("midrst_no_ghost", 32'(count), 32'd0);

    // Wrap-around: occupancy kept between 1 and 3.
    step(1'b1, $urandom, $urandom, $urandom, 1'b0, 1'b0);
    step(1'b1, $urandom, $urandom, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, $urandom, $urandom, $urandom, (count == 3) || (i % 2 == 1), 1'b0);
      if (count > 3) cmp("wrap_count_max", 32'(count), 32'd3);
    end
    for (int i = 0; i < 6; i++) step(1'b0, '0, '0, '0, 1'b1, 1'b0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 99) == 0));
    end
    for (int i = 0; i < 6; i++) step(1'b0, '0, '0, '0, 1'b1, 1'b0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
